bram_16384x1_tdp: RTL and testbench

//  True dual-port synchronous block RAM, 16384 words x 1 bit, one shared clock.

---
 rtl/bram_pkg.sv | 19 +
 rtl/bram_port_out.sv | 43 ++++
 rtl/bram_16384x1_tdp.sv | 86 ++++++++
 tb/tb_bram_16384x1_tdp.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// ============================================================================
// Module   : bram_pkg
// Brief    : Shared sizing constants and types for the 16384x1 true dual-port RAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bram_pkg;

    localparam int BRAM_ADDR_W = 14;
    localparam int BRAM_DATA_W = 1;
    localparam int BRAM_DEPTH  = 2 ** BRAM_ADDR_W;

    typedef logic [BRAM_ADDR_W-1:0] bram_addr_t;
    typedef logic [BRAM_DATA_W-1:0] bram_data_t;

endpackage

`default_nettype wire

// File: rtl/bram_port_out.sv
// ============================================================================
// Module   : bram_port_out
// Brief    : Per-port read-data register; async active-low clear, loads only
//            on enabled cycles so the output holds while the port is idle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_port_out
    import bram_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (i_ce) begin
            q_d = i_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

`default_nettype wire

// File: rtl/bram_16384x1_tdp.sv
// ============================================================================
// Module   : bram_16384x1_tdp
// Brief    : 16384x1 true dual-port read-first block RAM, single clock.
//            Optional simulation collision checker: BRAM_COLLISION_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_16384x1_tdp
    import bram_pkg::*;
#(
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CE0,
    input  logic [ADDR_W-1:0] A0,
    input  logic [DATA_W-1:0] D0,
    input  logic              WE0,
    input  logic [DATA_W-1:0] WEM0,
    output logic [DATA_W-1:0] Q0,
    input  logic              CE1,
    input  logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] D1,
    input  logic              WE1,
    input  logic [DATA_W-1:0] WEM1,
    output logic [DATA_W-1:0] Q1
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;

    // Port 1 is applied after port 0 so its bits win on a same-address write.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DATA_W; i++) begin
            if (CE0 && WE0 && WEM0[i]) begin
                mem[A0][i] <= D0[i];
            end
            if (CE1 && WE1 && WEM1[i]) begin
                mem[A1][i] <= D1[i];
            end
        end
    end

    // Sampled before this edge's writes land, giving read-first on both ports.
    assign w_rd0 = mem[A0];
    assign w_rd1 = mem[A1];

    bram_port_out #(
        .DATA_W (DATA_W)
    ) u_port0_out (
        .i_clk     (CLK),
        .i_rst_n   (RSTN),
        .i_ce      (CE0),
        .i_rd_data (w_rd0),
        .o_q       (Q0)
    );

    bram_port_out #(
        .DATA_W (DATA_W)
    ) u_port1_out (
        .i_clk     (CLK),
        .i_rst_n   (RSTN),
        .i_ce      (CE1),
        .i_rd_data (w_rd1),
        .o_q       (Q1)
    );

`ifdef BRAM_COLLISION_CHECK_EN
    always @(posedge CLK) begin
        if (CE0 && CE1 && (WE0 || WE1) && (A0 == A1)) begin
            $display("collision in %m at address 0x%0h", A0);
            $finish;
        end
    end
`else
    // Same-address collisions resolve silently through the write priority above.
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_16384x1_tdp.sv
// ============================================================================
// Module   : tb_bram_16384x1_tdp
// Brief    : Scoreboard bench for bram_16384x1_tdp with a reference memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bram_16384x1_tdp;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        CE0, CE1, WE0, WE1;
    logic [13:0] A0, A1;
    logic [0:0]  D0, D1, WEM0, WEM1;
    logic [0:0]  Q0, Q1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit    port;
        bit    val;
        string tag;
    } sb_item_t;

    sb_item_t sb_q[$];
    bit       mem_m [int];
    bit       q0_m, q1_m;
    bit       q0_known, q1_known;

    always #5 CLK = ~CLK;

    bram_16384x1_tdp u_dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .CE0  (CE0),
        .A0   (A0),
        .D0   (D0),
        .WE0  (WE0),
        .WEM0 (WEM0),
        .Q0   (Q0),
        .CE1  (CE1),
        .A1   (A1),
        .D1   (D1),
        .WE1  (WE1),
        .WEM1 (WEM1),
        .Q1   (Q1)
    );

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; expected outputs are queued and checked after the edge.
    task automatic step(input string tag,
                        input bit ce0, input bit [13:0] a0, input bit d0, input bit we0, input bit wem0,
                        input bit ce1, input bit [13:0] a1, input bit d1, input bit we1, input bit wem1);
        sb_item_t it;
        @(negedge CLK);
        CE0 = ce0; A0 = a0; D0 = d0; WE0 = we0; WEM0 = wem0;
        CE1 = ce1; A1 = a1; D1 = d1; WE1 = we1; WEM1 = wem1;
        if (ce0) begin
            q0_known = mem_m.exists(int'(a0));
            if (q0_known) q0_m = mem_m[int'(a0)];
        end
        if (ce1) begin
            q1_known = mem_m.exists(int'(a1));
            if (q1_known) q1_m = mem_m[int'(a1)];
        end
        if (ce0 && we0 && wem0) mem_m[int'(a0)] = d0;
        if (ce1 && we1 && wem1) mem_m[int'(a1)] = d1;
        if (q0_known) begin
            it.port = 1'b0; it.val = q0_m; it.tag = {tag, "_q0"};
            sb_q.push_back(it);
        end
        if (q1_known) begin
            it.port = 1'b1; it.val = q1_m; it.tag = {tag, "_q1"};
            sb_q.push_back(it);
        end
        @(posedge CLK);
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_eq(it.tag, it.port ? Q1[0] : Q0[0], it.val);
        end
    endtask

    initial begin
        RSTN = 1'b0;
        CE0 = 0; CE1 = 0; WE0 = 0; WE1 = 0;
        A0 = '0; A1 = '0; D0 = '0; D1 = '0; WEM0 = '0; WEM1 = '0;
        q0_m = 0; q1_m = 0; q0_known = 1; q1_known = 1;

        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_q0", Q0[0], 1'b0);
        check_eq("rst_q1", Q1[0], 1'b0);
        @(negedge CLK);
        RSTN = 1'b1;

        // Uninitialised read after reset: contents undefined, not compared.
        step("t1", 0, 14'h0000, 0, 0, 0,  1, 14'h0000, 0, 0, 0);

        step("t2_wr", 1, 14'h3FFF, 1, 1, 1,  0, 14'h0000, 0, 0, 0);
        step("t2_rd", 0, 14'h0000, 0, 0, 0,  1, 14'h3FFF, 0, 0, 0);

        step("t3_init",   0, 14'h0000, 0, 0, 0,  1, 14'h0100, 0, 1, 1);
        step("t3_maskwr", 1, 14'h0100, 1, 1, 0,  0, 14'h0000, 0, 0, 0);
        step("t3_rd",     1, 14'h0100, 0, 0, 0,  0, 14'h0000, 0, 0, 0);

        step("t4_init", 0, 14'h0000, 0, 0, 0,  1, 14'h0042, 0, 1, 1);
        step("t4_rf",   1, 14'h0042, 1, 1, 1,  1, 14'h0042, 0, 0, 0);
        step("t4_rerd", 1, 14'h0042, 0, 0, 0,  1, 14'h0042, 0, 0, 0);

        // Q1 is 1 here; idle port 1 must hold regardless of address changes.
        for (int i = 0; i < 5; i++) begin
            step("t5_hold", 0, 14'h0000, 0, 0, 0,  0, 14'(i * 777), 1, 1, 1);
        end
        @(negedge CLK);
        #2;
        RSTN = 1'b0;
        #1;
        check_eq("t5_async_q1", Q1[0], 1'b0);
        check_eq("t5_async_q0", Q0[0], 1'b0);
        q0_m = 0; q1_m = 0; q0_known = 1; q1_known = 1;
        #1;
        RSTN = 1'b1;

        step("t6_coll",  1, 14'h1234, 0, 1, 1,  1, 14'h1234, 1, 1, 1);
        step("t6_rd",    1, 14'h1234, 0, 0, 0,  0, 14'h0000, 0, 0, 0);
        step("t6_coll2", 1, 14'h1234, 0, 1, 1,  1, 14'h1234, 1, 1, 0);
        step("t6_rd2",   1, 14'h1234, 0, 0, 0,  1, 14'h1234, 0, 0, 0);

        // Independent traffic on disjoint address windows, including dual writes.
        for (int i = 0; i < 40; i++) begin
            step("rnd",
                 bit'($urandom_range(0, 1)), 14'(14'h2000 + $urandom_range(0, 7)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), 14'(14'h2100 + $urandom_range(0, 7)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
